// File: rtl/pad_in_sync_filter.sv
// Input pad glue: synchroniser chain, debounce filter with rise/fall pulses.
// Optional sticky interrupt (irq_* ports) is built when PAD_IN_IRQ_EN is defined.
module pad_in_sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pad_c_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] debounce_cycles_i,
`ifdef PAD_IN_IRQ_EN
  input  logic             irq_rise_en_i,
  input  logic             irq_fall_en_i,
  input  logic             irq_clr_i,
  output logic             irq_o,
`endif
  output logic             sync_o,
  output logic             filt_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             dbg_state_o
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   mis;
  logic                   flip;

  // Stage 0 captures the asynchronous pad; the last stage is the usable value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_c_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign mis    = sync_o ^ filt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    if (!en_i) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (mis) begin
            if (debounce_cycles_i == '0) begin
              flip = 1'b1;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (!mis) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q >= debounce_cycles_i) begin
            // >= lets a live decrease of the threshold take effect immediately
            flip    = 1'b1;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
    end
  end

  always_comb begin
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (flip) begin
      filt_d = ~filt_q;
      rise_d = ~filt_q;
      fall_d = filt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      filt_q  <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign filt_o      = filt_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign dbg_state_o = (state_q == ST_COUNT);

`ifdef PAD_IN_IRQ_EN
  logic irq_q, irq_d;

  // A qualifying pulse wins over a coincident clear.
  always_comb begin
    irq_d = irq_q;
    if ((rise_q & irq_rise_en_i) | (fall_q & irq_fall_en_i)) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_pad_in_sync_filter.sv
// Bench for pad_in_sync_filter: directed literal checks plus randomized traffic
// compared every cycle against a run-length model of the debounce rule.
module tb_pad_in_sync_filter;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 16;
  localparam logic        RESET_VAL   = 1'b0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pad = 1'b1;
  logic             en  = 1'b1;
  logic [CNT_W-1:0] dbc = 16'd3;
  logic             sync_o, filt_o, rise_o, fall_o, dbg_state_o;
  logic             ire = 1'b0, ife = 1'b0, clr = 1'b0;
`ifdef PAD_IN_IRQ_EN
  logic             irq_o;
`endif

  int errors = 0;
  int checks = 0;

  pad_in_sync_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .RESET_VAL  (RESET_VAL)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pad_c_i          (pad),
    .en_i             (en),
    .debounce_cycles_i(dbc),
`ifdef PAD_IN_IRQ_EN
    .irq_rise_en_i    (ire),
    .irq_fall_en_i    (ife),
    .irq_clr_i        (clr),
    .irq_o            (irq_o),
`endif
    .sync_o           (sync_o),
    .filt_o           (filt_o),
    .rise_o           (rise_o),
    .fall_o           (fall_o),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pad history: index 0 is the newest captured sample, index SYNC_STAGES-1 is visible.
  logic hist[$];
  logic filt_m = RESET_VAL;
  logic rise_m = 1'b0;
  logic fall_m = 1'b0;
  logic irq_m  = 1'b0;
  int   run_m  = 0;   // consecutive enabled edges that saw sync != filt without acceptance

  initial begin
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(RESET_VAL);
  end

  always @(posedge clk) begin
    logic s;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(RESET_VAL);
      filt_m = RESET_VAL;
      run_m  = 0;
      rise_m = 1'b0;
      fall_m = 1'b0;
      irq_m  = 1'b0;
    end else begin
      s = hist[SYNC_STAGES-1];
      if ((rise_m && ire) || (fall_m && ife)) irq_m = 1'b1;
      else if (clr) irq_m = 1'b0;
      rise_m = 1'b0;
      fall_m = 1'b0;
      if (en && (s != filt_m)) begin
        // accepted once the mismatch has been seen on D+1 consecutive edges
        if (run_m >= int'(dbc)) begin
          filt_m = ~filt_m;
          rise_m = filt_m;
          fall_m = ~filt_m;
          run_m  = 0;
        end else begin
          run_m++;
        end
      end else begin
        run_m = 0;
      end
      hist.push_front(pad);
      void'(hist.pop_back());
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(posedge clk) begin
    #2;
    chk("sync_o", {31'd0, sync_o}, {31'd0, hist[SYNC_STAGES-1]});
    chk("filt_o", {31'd0, filt_o}, {31'd0, filt_m});
    chk("rise_o", {31'd0, rise_o}, {31'd0, rise_m});
    chk("fall_o", {31'd0, fall_o}, {31'd0, fall_m});
    chk("pulse_excl", {31'd0, rise_o & fall_o}, 32'd0);
    chk("dbg_state", {31'd0, dbg_state_o}, {31'd0, (run_m != 0)});
`ifdef PAD_IN_IRQ_EN
    chk("irq_o", {31'd0, irq_o}, {31'd0, irq_m});
`endif
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  initial begin
    int hold;
    // reset with pad high
    repeat (2) begin
      tick();
      lit("rst_sync", sync_o, 1'b0);
      lit("rst_filt", filt_o, 1'b0);
      lit("rst_rise", rise_o, 1'b0);
      lit("rst_fall", fall_o, 1'b0);
    end
    rst = 1'b0;
    pad = 1'b0;
    repeat (8) tick();
    lit("idle_filt", filt_o, 1'b0);

    // clean edge, D=3: visible after edge k+5 (6th edge)
    pad = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick();
      lit("clean_filt", filt_o, (j >= 6));
      lit("clean_rise", rise_o, (j == 6));
    end
    pad = 1'b0;
    repeat (10) tick();
    lit("back_low", filt_o, 1'b0);

    // glitch: two cycles high is too short for D=3
    pad = 1'b1;
    tick();
    tick();
    pad = 1'b0;
    repeat (8) begin
      tick();
      lit("glitch_filt", filt_o, 1'b0);
      lit("glitch_rise", rise_o, 1'b0);
    end
    lit("glitch_cnt_idle", dbg_state_o, 1'b0);

    // D=0: visible after edge k+2
    dbc = 16'd0;
    pad = 1'b1;
    tick(); lit("d0_e0", filt_o, 1'b0);
    tick(); lit("d0_e1", filt_o, 1'b0);
    tick(); lit("d0_e2", filt_o, 1'b1); lit("d0_rise", rise_o, 1'b1);

    // live change of D mid-count: D=10, count reaches 5, then D=2
    dbc = 16'd10;
    pad = 1'b0;
    repeat (7) tick();
    lit("live_hold", filt_o, 1'b1);
    lit("live_counting", dbg_state_o, 1'b1);
    dbc = 16'd2;
    tick();
    lit("live_flip", filt_o, 1'b0);
    lit("live_fall", fall_o, 1'b1);

    // disabled: toggling pad is ignored
    dbc = 16'd3;
    en  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pad = ~pad;
      tick();
      lit("dis_filt", filt_o, 1'b0);
      lit("dis_rise", rise_o, 1'b0);
      lit("dis_fall", fall_o, 1'b0);
    end
    pad = 1'b1;
    repeat (3) tick();
    en = 1'b1;
    repeat (3) begin
      tick();
      lit("reen_wait", filt_o, 1'b0);
    end
    tick();
    lit("reen_accept", filt_o, 1'b1);
    lit("reen_rise", rise_o, 1'b1);

`ifdef PAD_IN_IRQ_EN
    dbc = 16'd0;
    ife = 1'b1;
    pad = 1'b0;
    repeat (3) tick();
    lit("irq_fall_pulse", fall_o, 1'b1);
    lit("irq_not_yet", irq_o, 1'b0);
    tick();
    lit("irq_set", irq_o, 1'b1);
    clr = 1'b1;
    tick();
    lit("irq_clr", irq_o, 1'b0);
    clr = 1'b0;
    pad = 1'b1;
    repeat (4) tick();
    lit("irq_rise_masked", irq_o, 1'b0);
    pad = 1'b0;
    repeat (3) tick();
    lit("irq_fall2", fall_o, 1'b1);
    clr = 1'b1;
    tick();
    lit("irq_set_wins", irq_o, 1'b1);
    clr = 1'b0;
`endif

    // randomized traffic
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        pad  = ~pad;
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 99) < 3) dbc = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 4) en = ~en;
      rst = ($urandom_range(0, 999) < 4);
      ire = $urandom_range(0, 1);
      ife = $urandom_range(0, 1);
      clr = ($urandom_range(0, 99) < 10);
      tick();
    end
    rst = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
